// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one 4-bit ALU between two valid/ready requesters.
// Registered operands, programmable settle time, single tagged response channel.
module alu_share_ctrl #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [1:0] req0_op,
    input  logic       req0_m,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [1:0] req1_op,
    input  logic       req1_m,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_op,
    output logic       alu_m,
    input  logic [3:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_data,
    output logic       busy
);

    localparam logic [3:0] SETTLE_INIT = 4'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       last_grant;
    logic       id_q;
    logic       busy_q;
    logic       rsp_valid_q;

    logic       grant_id;
    logic       grant_en;
    logic [3:0] sel_a;
    logic [3:0] sel_b;
    logic [1:0] sel_op;
    logic       sel_m;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant_id = 1'b0;
        unique case (req_valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

    assign grant_en = (state == IDLE) && (|req_valid) && !reset;

    always_comb begin
        req_ready = 2'b00;
        if (grant_en) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        sel_a  = req0_a;
        sel_b  = req0_b;
        sel_op = req0_op;
        sel_m  = req0_m;
        if (grant_id) begin
            sel_a  = req1_a;
            sel_b  = req1_b;
            sel_op = req1_op;
            sel_m  = req1_m;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            last_grant  <= 1'b1;
            id_q        <= 1'b0;
            alu_a       <= 4'd0;
            alu_b       <= 4'd0;
            alu_op      <= 2'd0;
            alu_m       <= 1'b0;
            rsp_data    <= 4'd0;
            rsp_id      <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_en) begin
                        alu_a      <= sel_a;
                        alu_b      <= sel_b;
                        alu_op     <= sel_op;
                        alu_m      <= sel_m;
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= SETTLE_INIT;
                        busy_q     <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_data    <= alu_result;
                        rsp_id      <= id_q;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: two instances (settle 1 and 4) driving
// behavioural ALUs, checked against a request-level reference model.
module tb_alu_share_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] req_valid;
    logic [1:0] req_valid4;
    logic [3:0] pa [2];
    logic [3:0] pb [2];
    logic [1:0] pop [2];
    logic       pm [2];

    logic [1:0] req_ready, req_ready4;
    logic [3:0] alu_a, alu_b, alu_a4, alu_b4;
    logic [1:0] alu_op, alu_op4;
    logic       alu_m, alu_m4;
    logic [3:0] alu_result, alu_result4;
    logic       rsp_valid, rsp_valid4;
    logic       rsp_ready, rsp_ready4;
    logic       rsp_id, rsp_id4;
    logic [3:0] rsp_data, rsp_data4;
    logic       busy, busy4;

    int errors = 0;
    int checks = 0;

    // Behavioural stand-in for the shared ALU.
    function automatic logic [3:0] alu_model(logic [3:0] a, logic [3:0] b,
                                             logic [1:0] op, logic m);
        logic [18:0] sh;
        sh = {15'd0, a} << b;
        if (op == 2'b00) return sh[3:0];
        if (op == 2'b01) return a & b;
        return m ? 4'(a + ~b + 4'd1) : 4'(a + b);
    endfunction

    assign alu_result  = alu_model(alu_a, alu_b, alu_op, alu_m);
    assign alu_result4 = alu_model(alu_a4, alu_b4, alu_op4, alu_m4);

    function automatic int ref_result(int a, int b, int op, int m);
        if (op == 0) return (a * (1 << b)) % 16;
        if (op == 1) return a & b;
        if (m != 0) return ((a - b) % 16 + 16) % 16;
        return (a + b) % 16;
    endfunction

    alu_share_ctrl #(.EXEC_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(pa[0]), .req0_b(pb[0]), .req0_op(pop[0]), .req0_m(pm[0]),
        .req1_a(pa[1]), .req1_b(pb[1]), .req1_op(pop[1]), .req1_m(pm[1]),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_m(alu_m),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    alu_share_ctrl #(.EXEC_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid4), .req_ready(req_ready4),
        .req0_a(pa[0]), .req0_b(pb[0]), .req0_op(pop[0]), .req0_m(pm[0]),
        .req1_a(pa[1]), .req1_b(pb[1]), .req1_op(pop[1]), .req1_m(pm[1]),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4), .alu_m(alu_m4),
        .alu_result(alu_result4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
        .rsp_id(rsp_id4), .rsp_data(rsp_data4), .busy(busy4)
    );

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = 2'b00;
        req_valid4 = 2'b00;
        rsp_ready  = 1'b1;
        rsp_ready4 = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic set_req(int i, logic [3:0] a, logic [3:0] b,
                           logic [1:0] op, logic m);
        pa[i]  = a;
        pb[i]  = b;
        pop[i] = op;
        pm[i]  = m;
    endtask

    task automatic rand_req(int i);
        set_req(i, 4'($urandom_range(15)), 4'($urandom_range(15)),
                2'($urandom_range(3)), 1'($urandom_range(1)));
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        req_valid  = 2'b11;
        req_valid4 = 2'b00;
        rsp_ready  = 1'b1;
        rsp_ready4 = 1'b1;
        set_req(0, 4'd1, 4'd2, 2'd2, 1'b0);
        set_req(1, 4'd3, 4'd4, 2'd1, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b want 00", req_ready);
        end
        checks++;
        if ({busy, rsp_valid, rsp_id} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000",
                     {busy, rsp_valid, rsp_id});
        end
        checks++;
        if ({alu_a, alu_b, alu_op, alu_m, rsp_data} !== 15'd0) begin
            errors++;
            $display("FAIL reset_regs: got %h want 0",
                     {alu_a, alu_b, alu_op, alu_m, rsp_data});
        end
        req_valid = 2'b00;
        reset     = 1'b0;
    endtask

    task automatic test_add();
        do_reset();
        set_req(0, 4'd3, 4'd5, 2'b10, 1'b0);
        req_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL add_ready: got %b want 01", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if ({busy, rsp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL add_exec: got %b want 10", {busy, rsp_valid});
        end
        checks++;
        if ({alu_a, alu_b, alu_op, alu_m} !== {4'd3, 4'd5, 2'b10, 1'b0}) begin
            errors++;
            $display("FAIL add_alu_in: got %h want %h",
                     {alu_a, alu_b, alu_op, alu_m},
                     {4'd3, 4'd5, 2'b10, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 4'd8}) begin
            errors++;
            $display("FAIL add_rsp: got v=%b id=%b d=%h want v=1 id=0 d=8",
                     rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        checks++;
        if ({busy, rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL add_idle: got %b want 00", {busy, rsp_valid});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ta [4] = '{4'd5, 4'd3, 4'hC, 4'd9};
        logic [3:0] tb [4] = '{4'd3, 4'd1, 4'hA, 4'd9};
        logic [1:0] to [4] = '{2'b11, 2'b00, 2'b01, 2'b10};
        logic       tm [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] te [4] = '{4'd2, 4'd6, 4'd8, 4'd2};
        int k = 0;
        int got = 0;
        int last_cyc = 0;
        logic seen;
        do_reset();
        set_req(1, ta[0], tb[0], to[0], tm[0]);
        req_valid = 2'b10;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (rsp_id !== 1'b1 || rsp_data !== te[got]) begin
                    errors++;
                    $display("FAIL b2b_rsp%0d: got id=%b d=%h want id=1 d=%h",
                             got, rsp_id, rsp_data, te[got]);
                end
                if (got > 0) begin
                    checks++;
                    if (cyc - last_cyc != 3) begin
                        errors++;
                        $display("FAIL b2b_period%0d: got %0d want 3",
                                 got, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                got++;
            end
            seen = req_ready[1];
            @(posedge clk);
            #1;
            if (seen) begin
                k++;
                if (k < 4) set_req(1, ta[k], tb[k], to[k], tm[k]);
                else req_valid = 2'b00;
            end
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d responses want 4", got);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_simultaneous();
        int exp_d [8];
        int gidx = 0;
        int nrsp = 0;
        int g;
        logic granted;
        do_reset();
        rand_req(0);
        rand_req(1);
        req_valid = 2'b11;
        for (int cyc = 0; cyc < 60 && nrsp < 4; cyc++) begin
            @(negedge clk);
            granted = 1'b0;
            g = 0;
            checks++;
            if (req_ready === 2'b11) begin
                errors++;
                $display("FAIL sim_onehot: got %b want not 11", req_ready);
            end
            if (req_ready != 2'b00 && gidx < 8) begin
                g = req_ready[1] ? 1 : 0;
                checks++;
                if (g != gidx % 2) begin
                    errors++;
                    $display("FAIL sim_grant%0d: got %0d want %0d",
                             gidx, g, gidx % 2);
                end
                exp_d[gidx] = ref_result(pa[g], pb[g], pop[g], pm[g]);
                gidx++;
                granted = 1'b1;
            end
            if (rsp_valid && rsp_ready && nrsp < gidx) begin
                checks++;
                if (rsp_id !== 1'(nrsp % 2) ||
                    rsp_data !== 4'(exp_d[nrsp])) begin
                    errors++;
                    $display("FAIL sim_rsp%0d: got id=%b d=%h want id=%0d d=%h",
                             nrsp, rsp_id, rsp_data, nrsp % 2, exp_d[nrsp]);
                end
                nrsp++;
            end
            @(posedge clk);
            #1;
            if (granted) rand_req(g);
        end
        checks++;
        if (nrsp != 4) begin
            errors++;
            $display("FAIL sim_timeout: got %0d responses want 4", nrsp);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        logic found = 1'b0;
        do_reset();
        set_req(0, 4'd6, 4'd2, 2'b10, 1'b0);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_accept: got %b want 01", req_ready);
        end
        @(posedge clk);
        #1;
        set_req(1, 4'd7, 4'd7, 2'b01, 1'b0);
        req_valid = 2'b10;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = rsp_valid;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL bp_timeout: got no rsp_valid want 1");
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rsp_valid, rsp_data, req_ready} !== {1'b1, 4'd8, 2'b00} ||
                {alu_a, alu_b, alu_op} !== {4'd6, 4'd2, 2'b10}) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b d=%h rdy=%b alu=%h want v=1 d=8 rdy=00 alu=%h",
                         i, rsp_valid, rsp_data, req_ready,
                         {alu_a, alu_b, alu_op}, {4'd6, 4'd2, 2'b10});
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, req_ready} !== 3'b100) begin
            errors++;
            $display("FAIL bp_handshake: got %b want 100", {rsp_valid, req_ready});
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, req_ready} !== 3'b010) begin
            errors++;
            $display("FAIL bp_release: got %b want 010", {rsp_valid, req_ready});
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 4'd7}) begin
            errors++;
            $display("FAIL bp_second: got v=%b id=%b d=%h want v=1 id=1 d=7",
                     rsp_valid, rsp_id, rsp_data);
        end
    endtask

    task automatic test_settle();
        do_reset();
        set_req(0, 4'hF, 4'd1, 2'b10, 1'b0);
        req_valid4 = 2'b01;
        @(negedge clk);
        checks++;
        if (req_ready4 !== 2'b01) begin
            errors++;
            $display("FAIL settle_accept: got %b want 01", req_ready4);
        end
        @(posedge clk);
        #1 req_valid4 = 2'b00;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid4, busy4, alu_a4} !== {1'b0, 1'b1, 4'hF}) begin
                errors++;
                $display("FAIL settle_exec%0d: got v=%b busy=%b a=%h want v=0 busy=1 a=f",
                         j, rsp_valid4, busy4, alu_a4);
            end
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid4, rsp_id4, rsp_data4} !== {1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL settle_rsp: got v=%b id=%b d=%h want v=1 id=0 d=0",
                     rsp_valid4, rsp_id4, rsp_data4);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(0, 4'd4, 4'd3, 2'b10, 1'b0);
        req_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rmid_accept: got %b want 01", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, rsp_valid, alu_a, alu_b, alu_op, alu_m} !== 13'd0) begin
            errors++;
            $display("FAIL rmid_cleared: got %h want 0",
                     {busy, rsp_valid, alu_a, alu_b, alu_op, alu_m});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rmid_dropped%0d: got %b want 0", i, rsp_valid);
            end
        end
        @(posedge clk);
        #1;
        set_req(0, 4'd7, 4'd2, 2'b11, 1'b1);
        set_req(1, 4'd1, 4'd1, 2'b10, 1'b0);
        req_valid = 2'b11;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rmid_tie: got %b want 01", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 4'd5}) begin
            errors++;
            $display("FAIL rmid_after: got v=%b id=%b d=%h want v=1 id=0 d=5",
                     rsp_valid, rsp_id, rsp_data);
        end
    endtask

    // Request-level model: the controller is either free or owns one
    // outstanding transaction; ties alternate on the last grant.
    task automatic test_random();
        int q_id [$];
        int q_d [$];
        logic last = 1'b1;
        logic outst = 1'b0;
        logic [1:0] exp_rdy;
        logic [1:0] used;
        int g;
        do_reset();
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(negedge clk);
            exp_rdy = 2'b00;
            g = 0;
            if (!outst && req_valid != 2'b00) begin
                if (req_valid == 2'b11) g = last ? 0 : 1;
                else g = req_valid[1] ? 1 : 0;
                exp_rdy = (g == 1) ? 2'b10 : 2'b01;
            end
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rnd_ready@%0d: got %b want %b",
                         cyc, req_ready, exp_rdy);
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (q_id.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious@%0d: got rsp want none", cyc);
                end else begin
                    if (rsp_id !== 1'(q_id[0]) || rsp_data !== 4'(q_d[0])) begin
                        errors++;
                        $display("FAIL rnd_rsp@%0d: got id=%b d=%h want id=%0d d=%h",
                                 cyc, rsp_id, rsp_data, q_id[0], q_d[0]);
                    end
                    void'(q_id.pop_front());
                    void'(q_d.pop_front());
                end
                outst = 1'b0;
            end
            used = 2'b00;
            if (exp_rdy != 2'b00) begin
                q_id.push_back(g);
                q_d.push_back(ref_result(pa[g], pb[g], pop[g], pm[g]));
                last = 1'(g);
                outst = 1'b1;
                used[g] = 1'b1;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (used[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && cyc < 400 && $urandom_range(1) == 1) begin
                    rand_req(i);
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = (cyc >= 400) || ($urandom_range(9) < 7);
        end
        checks++;
        if (q_id.size() != 0 || req_valid != 2'b00) begin
            errors++;
            $display("FAIL rnd_drain: got %0d pending want 0", q_id.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_simultaneous();
        test_backpressure();
        test_settle();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
